// File: rtl/rp8_io_timer.sv
// rp8 I/O-bus timer/counter: prescaled 8-bit up-counter with output compare,
// overflow flags and two acknowledgeable interrupt requests.
module rp8_io_timer #(
    parameter logic [5:0] BASE    = 6'h20,
    parameter logic [7:0] OCR_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_wen,
    input  logic       io_ren,
    input  logic [5:0] io_adr,
    input  logic [7:0] io_wdt,
    input  logic [7:0] io_msk,
    output logic [7:0] io_rdt,
    output logic [1:0] irq_req,
    input  logic [1:0] irq_ack
);

    logic [6:0] r_tccr;
    logic [7:0] r_tcnt;
    logic [7:0] r_ocr;
    logic       r_ocf;
    logic       r_tov;
    logic [6:0] r_psc;

    logic       w_hit;
    logic       w_wr_tccr;
    logic       w_wr_tcnt;
    logic       w_wr_ocr;
    logic       w_wr_tifr;
    logic       w_en;
    logic [2:0] w_ps;
    logic       w_ctc;
    logic [6:0] w_ps_lim;
    logic       w_tick;
    logic       w_cnt;
    logic       w_match;
    logic       w_ocf_set;
    logic       w_tov_set;
    logic       w_ocf_clr;
    logic       w_tov_clr;
    logic [7:0] w_rdata;

    assign w_hit     = (io_adr[5:2] == BASE[5:2]);
    assign w_wr_tccr = io_wen && w_hit && (io_adr[1:0] == 2'd0);
    assign w_wr_tcnt = io_wen && w_hit && (io_adr[1:0] == 2'd1);
    assign w_wr_ocr  = io_wen && w_hit && (io_adr[1:0] == 2'd2);
    assign w_wr_tifr = io_wen && w_hit && (io_adr[1:0] == 2'd3);

    assign w_en  = r_tccr[0];
    assign w_ps  = r_tccr[3:1];
    assign w_ctc = r_tccr[4];

    // Prescaler terminal count is 2^PS-1, so PS=0 ticks every enabled cycle.
    assign w_ps_lim = 7'((8'd1 << w_ps) - 8'd1);
    assign w_tick   = w_en && (r_psc == w_ps_lim);

    // A bus write to TCNT swallows a coincident tick entirely, flags included.
    assign w_cnt     = w_tick && !w_wr_tcnt;
    assign w_match   = (r_tcnt == r_ocr);
    assign w_ocf_set = w_cnt && w_match;
    assign w_tov_set = w_cnt && (r_tcnt == 8'hFF);
    assign w_ocf_clr = (w_wr_tifr && io_wdt[0] && io_msk[0]) || irq_ack[0];
    assign w_tov_clr = (w_wr_tifr && io_wdt[1] && io_msk[1]) || irq_ack[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psc <= 7'd0;
        end else if (w_wr_tccr || !w_en || w_tick) begin
            r_psc <= 7'd0;
        end else begin
            r_psc <= r_psc + 7'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tccr <= 7'd0;
            r_ocr  <= OCR_RST;
        end else begin
            if (w_wr_tccr) begin
                r_tccr <= (io_wdt[6:0] & io_msk[6:0]) | (r_tccr & ~io_msk[6:0]);
            end
            if (w_wr_ocr) begin
                r_ocr <= (io_wdt & io_msk) | (r_ocr & ~io_msk);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= 8'd0;
        end else if (w_wr_tcnt) begin
            r_tcnt <= (io_wdt & io_msk) | (r_tcnt & ~io_msk);
        end else if (w_tick) begin
            r_tcnt <= (w_ctc && w_match) ? 8'd0 : r_tcnt + 8'd1;
        end
    end

    // Set has priority over both the W1C write and the core acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ocf <= 1'b0;
            r_tov <= 1'b0;
        end else begin
            if (w_ocf_set) begin
                r_ocf <= 1'b1;
            end else if (w_ocf_clr) begin
                r_ocf <= 1'b0;
            end
            if (w_tov_set) begin
                r_tov <= 1'b1;
            end else if (w_tov_clr) begin
                r_tov <= 1'b0;
            end
        end
    end

    // Read data is zero when idle or unaddressed so responders can be OR-ed.
    always_comb begin
        w_rdata = 8'h00;
        if (io_ren && w_hit) begin
            case (io_adr[1:0])
                2'd0:    w_rdata = {1'b0, r_tccr};
                2'd1:    w_rdata = r_tcnt;
                2'd2:    w_rdata = r_ocr;
                default: w_rdata = {6'd0, r_tov, r_ocf};
            endcase
        end
    end

    assign io_rdt  = w_rdata;
    assign irq_req = {r_tov && r_tccr[6], r_ocf && r_tccr[5]};

endmodule

// File: tb/tb_rp8_io_timer.sv
// Directed bench for rp8_io_timer: stimulus pushes expected read data and irq
// state into a scoreboard queue; a negedge monitor pops and compares.
module tb_rp8_io_timer;

    localparam logic [5:0] A_TCCR = 6'h20;
    localparam logic [5:0] A_TCNT = 6'h21;
    localparam logic [5:0] A_OCR  = 6'h22;
    localparam logic [5:0] A_TIFR = 6'h23;
    localparam logic [5:0] A_MISS = 6'h24;

    logic       clk;
    logic       rst;
    logic       io_wen;
    logic       io_ren;
    logic [5:0] io_adr;
    logic [7:0] io_wdt;
    logic [7:0] io_msk;
    logic [7:0] io_rdt;
    logic [1:0] irq_req;
    logic [1:0] irq_ack;

    typedef struct {
        string      nm;
        logic [7:0] exp;
        bit         is_irq;
    } sb_t;

    sb_t sb_q[$];
    bit  chk_req;
    int  n_chk;
    int  n_err;
    int  n_issued;

    rp8_io_timer #(.BASE(6'h20), .OCR_RST(8'hFF)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_wen  (io_wen),
        .io_ren  (io_ren),
        .io_adr  (io_adr),
        .io_wdt  (io_wdt),
        .io_msk  (io_msk),
        .io_rdt  (io_rdt),
        .irq_req (irq_req),
        .irq_ack (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_req) begin
            while (sb_q.size() > 0) begin
                sb_t e;
                logic [7:0] act;
                e   = sb_q.pop_front();
                act = e.is_irq ? {6'd0, irq_req} : io_rdt;
                n_chk++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %02h expected %02h", e.nm, act, e.exp);
                end
            end
        end
    end

    task automatic wr(input logic [5:0] adr, input logic [7:0] wdt, input logic [7:0] msk);
        io_wen = 1'b1;
        io_adr = adr;
        io_wdt = wdt;
        io_msk = msk;
        @(posedge clk);
        #1;
        io_wen = 1'b0;
        io_wdt = 8'h00;
        io_msk = 8'h00;
    endtask

    // One cycle: read adr, check read data and irq_req, optionally pulse irq_ack.
    task automatic chk(input logic [5:0] adr, input logic [7:0] exp_rd, input logic [1:0] exp_irq,
                       input string nm, input logic [1:0] ack = 2'b00, input logic ren = 1'b1);
        sb_t e;
        io_ren  = ren;
        io_adr  = adr;
        irq_ack = ack;
        e.nm = {nm, "/rdt"}; e.exp = exp_rd;          e.is_irq = 1'b0; sb_q.push_back(e);
        e.nm = {nm, "/irq"}; e.exp = {6'd0, exp_irq}; e.is_irq = 1'b1; sb_q.push_back(e);
        n_issued += 2;
        chk_req = 1'b1;
        @(posedge clk);
        #1;
        chk_req = 1'b0;
        io_ren  = 1'b0;
        irq_ack = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_err = 0; n_issued = 0; chk_req = 1'b0;
        rst = 1'b1; io_wen = 1'b0; io_ren = 1'b0; io_adr = 6'h00;
        io_wdt = 8'h00; io_msk = 8'h00; irq_ack = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and decode
        chk(A_TCCR, 8'h00, 2'b00, "rst_tccr");
        chk(A_TCNT, 8'h00, 2'b00, "rst_tcnt");
        chk(A_OCR,  8'hFF, 2'b00, "rst_ocr");
        chk(A_TIFR, 8'h00, 2'b00, "rst_tifr");
        chk(A_MISS, 8'h00, 2'b00, "miss_rd");
        chk(A_OCR,  8'h00, 2'b00, "ren_low", 2'b00, 1'b0);

        // Masked writes, reserved bit, miss write
        wr(A_TCCR, 8'hFF, 8'h0F);
        chk(A_TCCR, 8'h0F, 2'b00, "msk_tccr1");
        wr(A_TCCR, 8'h00, 8'h01);
        chk(A_TCCR, 8'h0E, 2'b00, "msk_tccr2");
        wr(A_TCCR, 8'h80, 8'h80);
        chk(A_TCCR, 8'h0E, 2'b00, "tccr_rsvd");
        wr(A_MISS, 8'h00, 8'hFF);
        chk(A_OCR,  8'hFF, 2'b00, "miss_wr");

        // CTC with OCR=3, PS=0, OCIE
        wr(A_OCR, 8'h03, 8'hFF);
        wr(A_TCCR, 8'h31, 8'hFF);
        chk(A_TCNT, 8'h00, 2'b00, "ctc_c0");
        chk(A_TCNT, 8'h01, 2'b00, "ctc_c1");
        chk(A_TCNT, 8'h02, 2'b00, "ctc_c2");
        chk(A_TCNT, 8'h03, 2'b00, "ctc_c3");
        chk(A_TCNT, 8'h00, 2'b01, "ctc_wrap");
        chk(A_TIFR, 8'h01, 2'b01, "ctc_ocf");
        chk(A_TCNT, 8'h02, 2'b01, "ctc_ack", 2'b01);
        chk(A_TIFR, 8'h00, 2'b00, "ack_vs_set", 2'b01);
        chk(A_TIFR, 8'h01, 2'b01, "set_wins");
        wr(A_TCCR, 8'h00, 8'hFF);
        wr(A_TIFR, 8'h01, 8'h01);
        chk(A_TIFR, 8'h00, 2'b00, "ocf_w1c");
        chk(A_TCNT, 8'h02, 2'b00, "en0_frozen");

        // Overflow, PS=2, TOIE
        wr(A_TCNT, 8'hFE, 8'hFF);
        wr(A_TCCR, 8'h45, 8'hFF);
        chk(A_TCNT, 8'hFE, 2'b00, "ovf_c0");
        chk(A_TCNT, 8'hFE, 2'b00, "ovf_c1");
        chk(A_TCNT, 8'hFE, 2'b00, "ovf_c2");
        chk(A_TCNT, 8'hFE, 2'b00, "ovf_c3");
        chk(A_TCNT, 8'hFF, 2'b00, "ovf_c4");
        chk(A_TCNT, 8'hFF, 2'b00, "ovf_c5");
        chk(A_TCNT, 8'hFF, 2'b00, "ovf_c6");
        chk(A_TCNT, 8'hFF, 2'b00, "ovf_c7");
        chk(A_TCNT, 8'h00, 2'b10, "ovf_wrap");
        chk(A_TIFR, 8'h02, 2'b10, "ovf_tov");
        wr(A_TIFR, 8'h02, 8'h02);
        chk(A_TIFR, 8'h00, 2'b00, "tov_w1c");

        // TCNT write coincident with a tick
        chk(A_TCNT, 8'h01, 2'b00, "pre_c12");
        chk(A_TCNT, 8'h01, 2'b00, "pre_c13");
        chk(A_TCNT, 8'h01, 2'b00, "pre_c14");
        wr(A_TCNT, 8'h10, 8'hFF);
        chk(A_TCNT, 8'h10, 2'b00, "wr_wins0");
        chk(A_TCNT, 8'h10, 2'b00, "wr_wins1");
        chk(A_TCNT, 8'h10, 2'b00, "wr_wins2");
        chk(A_TCNT, 8'h10, 2'b00, "wr_wins3");
        chk(A_TCNT, 8'h11, 2'b00, "post_inc");

        // Async reset mid-count with TOV pending
        wr(A_TCNT, 8'hFF, 8'hFF);
        chk(A_TCNT, 8'hFF, 2'b00, "pre_rst0");
        chk(A_TCNT, 8'hFF, 2'b00, "pre_rst1");
        chk(A_TIFR, 8'h02, 2'b10, "pre_rst_tov");
        rst = 1'b1;
        chk(A_TCCR, 8'h00, 2'b00, "rst2_tccr");
        chk(A_TCNT, 8'h00, 2'b00, "rst2_tcnt");
        chk(A_OCR,  8'hFF, 2'b00, "rst2_ocr");
        chk(A_TIFR, 8'h00, 2'b00, "rst2_tifr");
        rst = 1'b0;
        chk(A_TCNT, 8'h00, 2'b00, "idle0");
        chk(A_TCNT, 8'h00, 2'b00, "idle1");
        wr(A_TCCR, 8'h01, 8'hFF);
        chk(A_TCNT, 8'h00, 2'b00, "resume0");
        chk(A_TCNT, 8'h01, 2'b00, "resume1");
        chk(A_TCNT, 8'h02, 2'b00, "resume2");

        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries never checked", sb_q.size());
        end
        if (n_chk != n_issued) begin
            n_err++;
            $display("FAIL check count: ran %0d of %0d issued", n_chk, n_issued);
        end
        if (n_err != 0) begin
            $display("FAIL Result: errors=%0d of %0d checks", n_err, n_chk);
        end else begin
            $display("PASS Result: errors=%0d of %0d checks", n_err, n_chk);
        end
        $finish;
    end

endmodule
